// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared constants for the register-file write-back arbiter.
package regfile_wb_arbiter_pkg;

    localparam int unsigned REG_BUS_W  = 32;
    localparam int unsigned REG_ADDR_W = 5;

    localparam logic WRITE_ENABLE  = 1'b1;
    localparam logic WRITE_DISABLE = 1'b0;
    localparam logic RST_ENABLE    = 1'b0;

endpackage

// File: rtl/regfile_wb_arbiter_wb_kill_fifo.sv
// Secondary write queue with per-entry valid bits, address-match kill and,
// under WB_FWD_EN, a youngest-live-match lookup.
module regfile_wb_arbiter_wb_kill_fifo
    import regfile_wb_arbiter_pkg::*;
#(
    parameter int unsigned DATA_W = REG_BUS_W,
    parameter int unsigned ADDR_W = REG_ADDR_W,
    parameter int unsigned DEPTH  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [ADDR_W-1:0] push_addr,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    input  logic              kill,
    input  logic [ADDR_W-1:0] kill_addr,
    output logic              head_valid,
    output logic [ADDR_W-1:0] head_addr,
    output logic [DATA_W-1:0] head_data,
    output logic              full,
    output logic              empty,
    output logic              any_valid
`ifdef WB_FWD_EN
    ,
    input  logic [ADDR_W-1:0] q_addr,
    output logic              q_hit,
    output logic [DATA_W-1:0] q_data
`endif
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [ADDR_W-1:0] addr_q [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];
    logic [DEPTH-1:0]  vld_q;
    logic [PTR_W-1:0]  rptr_q, wptr_q;
    logic [CNT_W-1:0]  count_q;

    // Valid bits are cleared on pop, so unoccupied slots never read as live.
    always_ff @(posedge clk or negedge rst) begin
        if (rst == RST_ENABLE) begin
            for (int i = 0; i < DEPTH; i++) begin
                addr_q[i] <= '0;
                data_q[i] <= '0;
            end
            vld_q   <= '0;
            rptr_q  <= '0;
            wptr_q  <= '0;
            count_q <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (kill && vld_q[i] && addr_q[i] == kill_addr) vld_q[i] <= 1'b0;
            end
            if (pop) begin
                vld_q[rptr_q] <= 1'b0;
                rptr_q        <= rptr_q + PTR_W'(1);
            end
            // A same-cycle push is newer than the killing write, so it wins.
            if (push) begin
                vld_q[wptr_q]  <= 1'b1;
                addr_q[wptr_q] <= push_addr;
                data_q[wptr_q] <= push_data;
                wptr_q         <= wptr_q + PTR_W'(1);
            end
            if (push && !pop)      count_q <= count_q + CNT_W'(1);
            else if (!push && pop) count_q <= count_q - CNT_W'(1);
        end
    end

    assign head_valid = vld_q[rptr_q];
    assign head_addr  = addr_q[rptr_q];
    assign head_data  = data_q[rptr_q];
    assign full       = (count_q == CNT_W'(DEPTH));
    assign empty      = (count_q == '0);
    assign any_valid  = |vld_q;

`ifdef WB_FWD_EN
    logic [PTR_W-1:0] idx;

    // Walk oldest to youngest so the last match found is the youngest.
    always_comb begin
        q_hit  = 1'b0;
        q_data = '0;
        idx    = '0;
        for (int k = 0; k < DEPTH; k++) begin
            idx = rptr_q + PTR_W'(k);
            if (q_addr != '0 && vld_q[idx] && addr_q[idx] == q_addr) begin
                q_hit  = 1'b1;
                q_data = data_q[idx];
            end
        end
    end
`endif

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Merges primary write-back and queued secondary writes onto one regfile port.
// Optional decode-stage forwarding lookup enabled by defining WB_FWD_EN.
module regfile_wb_arbiter
    import regfile_wb_arbiter_pkg::*;
#(
    parameter int unsigned DATA_W     = REG_BUS_W,
    parameter int unsigned ADDR_W     = REG_ADDR_W,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              p_valid,
    input  logic [ADDR_W-1:0] p_waddr,
    input  logic [DATA_W-1:0] p_wdata,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [ADDR_W-1:0] s_waddr,
    input  logic [DATA_W-1:0] s_wdata,
    output logic              we,
    output logic [ADDR_W-1:0] waddr,
    output logic [DATA_W-1:0] wdata,
    output logic              pending
`ifdef WB_FWD_EN
    ,
    input  logic [ADDR_W-1:0] q_addr,
    output logic              q_hit,
    output logic [DATA_W-1:0] q_data
`endif
);

    logic              p_req;
    logic              push, pop;
    logic              head_valid, full, empty;
    logic [ADDR_W-1:0] head_addr;
    logic [DATA_W-1:0] head_data;

    // Register 0 is hard-wired, so writes to it are treated as no request.
    assign p_req   = p_valid && (p_waddr != '0);
    assign s_ready = !full;
    assign push    = s_valid && s_ready && (s_waddr != '0);
    assign pop     = !p_req && !empty;

    regfile_wb_arbiter_wb_kill_fifo #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (push),
        .push_addr  (s_waddr),
        .push_data  (s_wdata),
        .pop        (pop),
        .kill       (p_req),
        .kill_addr  (p_waddr),
        .head_valid (head_valid),
        .head_addr  (head_addr),
        .head_data  (head_data),
        .full       (full),
        .empty      (empty),
        .any_valid  (pending)
`ifdef WB_FWD_EN
        ,
        .q_addr     (q_addr),
        .q_hit      (q_hit),
        .q_data     (q_data)
`endif
    );

    always_ff @(posedge clk or negedge rst) begin
        if (rst == RST_ENABLE) begin
            we    <= WRITE_DISABLE;
            waddr <= '0;
            wdata <= '0;
        end else if (p_req) begin
            we    <= WRITE_ENABLE;
            waddr <= p_waddr;
            wdata <= p_wdata;
        end else if (pop && head_valid) begin
            we    <= WRITE_ENABLE;
            waddr <= head_addr;
            wdata <= head_data;
        end else begin
            // Idle cycle or killed entry popped: address/data hold.
            we    <= WRITE_DISABLE;
        end
    end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed self-checking bench for regfile_wb_arbiter.
module tb_regfile_wb_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        p_valid = 1'b0;
    logic [4:0]  p_waddr = '0;
    logic [31:0] p_wdata = '0;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic [4:0]  s_waddr = '0;
    logic [31:0] s_wdata = '0;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        pending;
`ifdef WB_FWD_EN
    logic [4:0]  q_addr = '0;
    logic        q_hit;
    logic [31:0] q_data;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    regfile_wb_arbiter dut (
        .clk     (clk),
        .rst     (rst),
        .p_valid (p_valid),
        .p_waddr (p_waddr),
        .p_wdata (p_wdata),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .s_waddr (s_waddr),
        .s_wdata (s_wdata),
        .we      (we),
        .waddr   (waddr),
        .wdata   (wdata),
        .pending (pending)
`ifdef WB_FWD_EN
        ,
        .q_addr  (q_addr),
        .q_hit   (q_hit),
        .q_data  (q_data)
`endif
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        p_valid = 1'b0; p_waddr = '0; p_wdata = '0;
        s_valid = 1'b0; s_waddr = '0; s_wdata = '0;
    endtask

    task automatic test_reset();
        #1;
        n_checks++; if (we !== 1'b0) begin n_fail++; $display("FAIL reset_we got %b want 0", we); end
        n_checks++; if (waddr !== 5'd0) begin n_fail++; $display("FAIL reset_waddr got %0d want 0", waddr); end
        n_checks++; if (wdata !== 32'd0) begin n_fail++; $display("FAIL reset_wdata got %h want 0", wdata); end
        n_checks++; if (pending !== 1'b0) begin n_fail++; $display("FAIL reset_pending got %b want 0", pending); end
        n_checks++; if (s_ready !== 1'b1) begin n_fail++; $display("FAIL reset_s_ready got %b want 1", s_ready); end
        step();
        rst = 1'b1;
        step();
    endtask

    task automatic test_primary();
        p_valid = 1'b1; p_waddr = 5'd3; p_wdata = 32'h11;
        step();
        n_checks++; if ({we, waddr, wdata} !== {1'b1, 5'd3, 32'h11}) begin
            n_fail++; $display("FAIL prim_write got we=%b a=%0d d=%h want 1/3/11", we, waddr, wdata); end
        p_waddr = 5'd0; p_wdata = 32'h22;
        step();
        n_checks++; if ({we, waddr, wdata} !== {1'b0, 5'd3, 32'h11}) begin
            n_fail++; $display("FAIL prim_addr0 got we=%b a=%0d d=%h want 0/3/11", we, waddr, wdata); end
        idle_inputs();
        step();
    endtask

    task automatic test_latency();
        s_valid = 1'b1; s_waddr = 5'd5; s_wdata = 32'hA;
        step();
        n_checks++; if (we !== 1'b0 || pending !== 1'b1) begin
            n_fail++; $display("FAIL lat_push got we=%b pend=%b want 0/1", we, pending); end
        idle_inputs();
        step();
        n_checks++; if ({we, waddr, wdata} !== {1'b1, 5'd5, 32'hA}) begin
            n_fail++; $display("FAIL lat_out got we=%b a=%0d d=%h want 1/5/a", we, waddr, wdata); end
        n_checks++; if (pending !== 1'b0) begin n_fail++; $display("FAIL lat_pend got %b want 0", pending); end
        step();
        n_checks++; if (we !== 1'b0) begin n_fail++; $display("FAIL lat_idle got %b want 0", we); end
    endtask

    task automatic test_full();
        p_valid = 1'b1; p_waddr = 5'd1; p_wdata = 32'h100;
        s_valid = 1'b1; s_waddr = 5'd5; s_wdata = 32'hA;
        step();
        n_checks++; if (s_ready !== 1'b1 || waddr !== 5'd1) begin
            n_fail++; $display("FAIL full_first got rdy=%b a=%0d want 1/1", s_ready, waddr); end
        p_waddr = 5'd2; p_wdata = 32'h200;
        s_waddr = 5'd6; s_wdata = 32'hB;
        step();
        n_checks++; if (s_ready !== 1'b0 || waddr !== 5'd2) begin
            n_fail++; $display("FAIL full_ready got rdy=%b a=%0d want 0/2", s_ready, waddr); end
        p_valid = 1'b0;
        s_waddr = 5'd8; s_wdata = 32'h99;
        step();
        n_checks++; if ({we, waddr, wdata, s_ready} !== {1'b1, 5'd5, 32'hA, 1'b1}) begin
            n_fail++; $display("FAIL full_pop1 got we=%b a=%0d d=%h rdy=%b want 1/5/a/1", we, waddr, wdata, s_ready); end
        idle_inputs();
        step();
        n_checks++; if ({we, waddr, wdata, pending} !== {1'b1, 5'd6, 32'hB, 1'b0}) begin
            n_fail++; $display("FAIL full_pop2 got we=%b a=%0d d=%h pend=%b want 1/6/b/0", we, waddr, wdata, pending); end
        step();
        n_checks++; if (we !== 1'b0) begin n_fail++; $display("FAIL full_dropped got we=%b want 0", we); end
    endtask

    task automatic test_priority();
        s_valid = 1'b1; s_waddr = 5'd7; s_wdata = 32'hC;
        step();
        s_valid = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            p_valid = 1'b1; p_waddr = 5'(i); p_wdata = 32'(i);
            step();
            n_checks++; if ({we, waddr, pending} !== {1'b1, 5'(i), 1'b1}) begin
                n_fail++; $display("FAIL prio_p%0d got we=%b a=%0d pend=%b want 1/%0d/1", i, we, waddr, pending, i); end
        end
        idle_inputs();
        step();
        n_checks++; if ({we, waddr, wdata, pending} !== {1'b1, 5'd7, 32'hC, 1'b0}) begin
            n_fail++; $display("FAIL prio_sec got we=%b a=%0d d=%h pend=%b want 1/7/c/0", we, waddr, wdata, pending); end
        step();
    endtask

    task automatic test_waw();
        s_valid = 1'b1; s_waddr = 5'd9; s_wdata = 32'hD;
        step();
        idle_inputs();
        p_valid = 1'b1; p_waddr = 5'd9; p_wdata = 32'hE;
        step();
        n_checks++; if ({we, waddr, wdata, pending} !== {1'b1, 5'd9, 32'hE, 1'b0}) begin
            n_fail++; $display("FAIL waw_kill got we=%b a=%0d d=%h pend=%b want 1/9/e/0", we, waddr, wdata, pending); end
        idle_inputs();
        step();
        n_checks++; if ({we, waddr, wdata} !== {1'b0, 5'd9, 32'hE}) begin
            n_fail++; $display("FAIL waw_pop got we=%b a=%0d d=%h want 0/9/e", we, waddr, wdata); end
        // Same-cycle push to the same register is newer and must survive.
        p_valid = 1'b1; p_waddr = 5'd9; p_wdata = 32'h77;
        s_valid = 1'b1; s_waddr = 5'd9; s_wdata = 32'h88;
        step();
        n_checks++; if ({wdata, pending} !== {32'h77, 1'b1}) begin
            n_fail++; $display("FAIL waw_same got d=%h pend=%b want 77/1", wdata, pending); end
        idle_inputs();
        step();
        n_checks++; if ({we, waddr, wdata} !== {1'b1, 5'd9, 32'h88}) begin
            n_fail++; $display("FAIL waw_newer got we=%b a=%0d d=%h want 1/9/88", we, waddr, wdata); end
        s_valid = 1'b1; s_waddr = 5'd0; s_wdata = 32'h5;
        step();
        n_checks++; if (pending !== 1'b0 || s_ready !== 1'b1) begin
            n_fail++; $display("FAIL sec_addr0 got pend=%b rdy=%b want 0/1", pending, s_ready); end
        idle_inputs();
        step();
        n_checks++; if (we !== 1'b0) begin n_fail++; $display("FAIL sec_addr0_we got %b want 0", we); end
    endtask

`ifdef WB_FWD_EN
    task automatic test_fwd();
        p_valid = 1'b1; p_waddr = 5'd1; p_wdata = 32'h1;
        s_valid = 1'b1; s_waddr = 5'd4; s_wdata = 32'h1;
        step();
        p_waddr = 5'd2; s_wdata = 32'h2;
        step();
        s_valid = 1'b0;
        q_addr = 5'd4; #1;
        n_checks++; if ({q_hit, q_data} !== {1'b1, 32'h2}) begin
            n_fail++; $display("FAIL fwd_hit got h=%b d=%h want 1/2", q_hit, q_data); end
        q_addr = 5'd0; #1;
        n_checks++; if ({q_hit, q_data} !== {1'b0, 32'h0}) begin
            n_fail++; $display("FAIL fwd_zero got h=%b d=%h want 0/0", q_hit, q_data); end
        q_addr = 5'd5; #1;
        n_checks++; if (q_hit !== 1'b0) begin n_fail++; $display("FAIL fwd_miss got %b want 0", q_hit); end
        idle_inputs();
        q_addr = '0;
        step();
        step();
        step();
    endtask
`endif

    task automatic test_reset_mid();
        p_valid = 1'b1; p_waddr = 5'd1; p_wdata = 32'h1;
        s_valid = 1'b1; s_waddr = 5'd10; s_wdata = 32'h1;
        step();
        p_waddr = 5'd2; s_waddr = 5'd11;
        step();
        n_checks++; if (pending !== 1'b1 || s_ready !== 1'b0 || we !== 1'b1) begin
            n_fail++; $display("FAIL rmid_pre got pend=%b rdy=%b we=%b want 1/0/1", pending, s_ready, we); end
        idle_inputs();
        rst = 1'b0; #1;
        n_checks++; if ({we, pending, s_ready} !== {1'b0, 1'b0, 1'b1}) begin
            n_fail++; $display("FAIL rmid_async got we=%b pend=%b rdy=%b want 0/0/1", we, pending, s_ready); end
        step();
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            n_checks++; if (we !== 1'b0) begin n_fail++; $display("FAIL rmid_nowrite%0d got %b want 0", i, we); end
        end
    endtask

    initial begin
        test_reset();
        test_primary();
        test_latency();
        test_full();
        test_priority();
        test_waw();
`ifdef WB_FWD_EN
        test_fwd();
`endif
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout got running want finished");
        $fatal(1);
    end

endmodule
